// File: rtl/disp_scan_ctrl_if.sv
// Bus bundle for the display scan controller: frame data in, decoder/anode drive out.
interface disp_scan_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                        load;
    logic [4*DIGITS-1:0]         hexs;
    logic [DIGITS-1:0]           points;
    logic [DIGITS-1:0]           les;
    logic                        lz_en;
    logic [3:0]                  hex;
    logic                        point;
    logic                        le;
    logic [DIGITS-1:0]           an;
    logic [$clog2(DIGITS)-1:0]   digit_idx;
    logic                        frame_start;

    modport master (
        output load, hexs, points, les, lz_en,
        input  hex, point, le, an, digit_idx, frame_start
    );

    modport slave (
        input  load, hexs, points, les, lz_en,
        output hex, point, le, an, digit_idx, frame_start
    );
endinterface

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Frame data is double-buffered and committed only when digit 0 is about to be driven.
module disp_scan_ctrl #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    disp_scan_ctrl_if.slave  bus
);
    localparam int IW = $clog2(DIGITS);
    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

    // A digit at or above position i with all-zero nibbles upward is a leading zero; digit 0 never is.
    function automatic logic [DIGITS-1:0] lz_blank(input logic [4*DIGITS-1:0] h, input logic en);
        logic [DIGITS-1:0] res;
        logic              zero_run;
        res      = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (h[4*i +: 4] == 4'h0);
            res[i]   = en & (i != 0) & zero_run;
        end
        return res;
    endfunction

    logic [PW-1:0]       presc_q, presc_d;
    logic                started_q, started_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [3:0]          hex_q, hex_d;
    logic                point_q, point_d;
    logic                le_q, le_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                fs_q, fs_d;
    logic [4*DIGITS-1:0] act_hex_q, act_hex_d, pnd_hex_q, pnd_hex_d;
    logic [DIGITS-1:0]   act_pt_q, act_pt_d, pnd_pt_q, pnd_pt_d;
    logic [DIGITS-1:0]   act_le_q, act_le_d, pnd_le_q, pnd_le_d;
    logic                act_lz_q, act_lz_d, pnd_lz_q, pnd_lz_d;
    logic                pnd_vld_q, pnd_vld_d;

    logic                tick_s;
    logic                commit_s;
    logic                blank_s;
    logic [IW-1:0]       new_idx_s;
    logic [DIGITS-1:0]   lzb_s;

    // Prescaler, scan position and buffer commit/capture decisions.
    always_comb begin
        tick_s    = (presc_q == PRESC_MAX);
        presc_d   = tick_s ? '0 : presc_q + 1'b1;
        new_idx_s = (!started_q || idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        commit_s  = tick_s && (new_idx_s == '0);

        act_hex_d = act_hex_q;
        act_pt_d  = act_pt_q;
        act_le_d  = act_le_q;
        act_lz_d  = act_lz_q;
        // A load landing on the commit tick bypasses the pending buffer entirely.
        if (commit_s && bus.load) begin
            act_hex_d = bus.hexs;
            act_pt_d  = bus.points;
            act_le_d  = bus.les;
            act_lz_d  = bus.lz_en;
        end else if (commit_s && pnd_vld_q) begin
            act_hex_d = pnd_hex_q;
            act_pt_d  = pnd_pt_q;
            act_le_d  = pnd_le_q;
            act_lz_d  = pnd_lz_q;
        end else begin
            act_hex_d = act_hex_q;
        end

        pnd_hex_d = pnd_hex_q;
        pnd_pt_d  = pnd_pt_q;
        pnd_le_d  = pnd_le_q;
        pnd_lz_d  = pnd_lz_q;
        pnd_vld_d = pnd_vld_q;
        if (bus.load && !commit_s) begin
            pnd_hex_d = bus.hexs;
            pnd_pt_d  = bus.points;
            pnd_le_d  = bus.les;
            pnd_lz_d  = bus.lz_en;
            pnd_vld_d = 1'b1;
        end else if (commit_s) begin
            pnd_vld_d = 1'b0;
        end else begin
            pnd_vld_d = pnd_vld_q;
        end
    end

    // Per-digit decoder and anode drive for the digit selected at this tick.
    always_comb begin
        lzb_s     = lz_blank(act_hex_d, act_lz_d);
        blank_s   = act_le_d[new_idx_s] | lzb_s[new_idx_s];
        started_d = started_q;
        idx_d     = idx_q;
        hex_d     = hex_q;
        point_d   = point_q;
        le_d      = le_q;
        an_d      = an_q;
        fs_d      = commit_s;
        if (tick_s) begin
            started_d = 1'b1;
            idx_d     = new_idx_s;
            hex_d     = act_hex_d[{new_idx_s, 2'b00} +: 4];
            point_d   = act_pt_d[new_idx_s] & ~blank_s;
            le_d      = blank_s;
            an_d      = ~(DIGITS'(1) << new_idx_s);
        end else begin
            started_d = started_q;
        end
    end

    // State registers; everything returns to a blanked, empty display on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            started_q <= 1'b0;
            idx_q     <= '0;
            hex_q     <= 4'h0;
            point_q   <= 1'b0;
            le_q      <= 1'b1;
            an_q      <= '1;
            fs_q      <= 1'b0;
            act_hex_q <= '0;
            act_pt_q  <= '0;
            act_le_q  <= '0;
            act_lz_q  <= 1'b0;
            pnd_hex_q <= '0;
            pnd_pt_q  <= '0;
            pnd_le_q  <= '0;
            pnd_lz_q  <= 1'b0;
            pnd_vld_q <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            started_q <= started_d;
            idx_q     <= idx_d;
            hex_q     <= hex_d;
            point_q   <= point_d;
            le_q      <= le_d;
            an_q      <= an_d;
            fs_q      <= fs_d;
            act_hex_q <= act_hex_d;
            act_pt_q  <= act_pt_d;
            act_le_q  <= act_le_d;
            act_lz_q  <= act_lz_d;
            pnd_hex_q <= pnd_hex_d;
            pnd_pt_q  <= pnd_pt_d;
            pnd_le_q  <= pnd_le_d;
            pnd_lz_q  <= pnd_lz_d;
            pnd_vld_q <= pnd_vld_d;
        end
    end

    assign bus.hex         = hex_q;
    assign bus.point       = point_q;
    assign bus.le          = le_q;
    assign bus.an          = an_q;
    assign bus.digit_idx   = idx_q;
    assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed + random bench for disp_scan_ctrl against a frame-level reference model.
module tb_disp_scan_ctrl;
    localparam int DG = 4;
    localparam int SD = 4;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    disp_scan_ctrl_if #(.DIGITS(DG)) bus ();

    disp_scan_ctrl #(.DIGITS(DG), .SCAN_DIV(SD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: edges since reset decide tick number and digit directly.
    int         k;
    int         a_hex [DG];
    bit         a_pt  [DG];
    bit         a_le  [DG];
    bit         a_lz;
    bit         pv;
    logic [15:0] p_hexs;
    logic [3:0]  p_pts, p_les;
    logic        p_lz;
    logic [3:0]  e_hex;
    logic        e_pt, e_le, e_fs;
    logic [3:0]  e_an;
    logic [1:0]  e_idx;

    task automatic model_reset();
        k = 0; pv = 1'b0; a_lz = 1'b0;
        for (int j = 0; j < DG; j++) begin a_hex[j] = 0; a_pt[j] = 1'b0; a_le[j] = 1'b0; end
        e_hex = 4'h0; e_pt = 1'b0; e_le = 1'b1; e_an = 4'hF; e_idx = 2'd0; e_fs = 1'b0;
    endtask

    task automatic take_active(input logic [15:0] h, input logic [3:0] p, input logic [3:0] l, input logic z);
        for (int j = 0; j < DG; j++) begin a_hex[j] = int'(h[4*j +: 4]); a_pt[j] = p[j]; a_le[j] = l[j]; end
        a_lz = z;
    endtask

    task automatic model_step();
        int d;
        bit commit, allz, blank;
        if (!rst_n) return;
        d      = (k % SD == SD - 1) ? (k / SD) % DG : -1;
        commit = (d == 0);
        if (commit && bus.load)  take_active(bus.hexs, bus.points, bus.les, bus.lz_en);
        else if (commit && pv)   take_active(p_hexs, p_pts, p_les, p_lz);
        if (commit) pv = 1'b0;
        else if (bus.load) begin
            p_hexs = bus.hexs; p_pts = bus.points; p_les = bus.les; p_lz = bus.lz_en; pv = 1'b1;
        end
        e_fs = commit;
        if (d >= 0) begin
            allz = 1'b1;
            for (int j = d; j < DG; j++) allz = allz && (a_hex[j] == 0);
            blank = a_le[d] || (a_lz && d > 0 && allz);
            e_hex = 4'(a_hex[d]);
            e_pt  = a_pt[d] && !blank;
            e_le  = blank;
            e_an  = 4'hF;
            e_an[d] = 1'b0;
            e_idx = 2'(d);
        end
        k++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("hex", 32'(bus.hex), 32'(e_hex));
        chk("point", 32'(bus.point), 32'(e_pt));
        chk("le", 32'(bus.le), 32'(e_le));
        chk("an", 32'(bus.an), 32'(e_an));
        chk("digit_idx", 32'(bus.digit_idx), 32'(e_idx));
        chk("frame_start", 32'(bus.frame_start), 32'(e_fs));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic wait_an(input logic [3:0] target);
        int n = 0;
        bit left = 1'b0;
        do begin
            cycle();
            n++;
            if (bus.an !== target) left = 1'b1;
        end while (!(left && bus.an === target) && n < 80);
        chk("wait_an", 32'(bus.an), 32'(target));
    endtask

    task automatic load_frame(input logic [15:0] h, input logic [3:0] p, input logic [3:0] l, input logic z);
        bus.hexs = h; bus.points = p; bus.les = l; bus.lz_en = z; bus.load = 1'b1;
        cycle();
        bus.load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        bus.load = 1'b0; bus.hexs = 16'h0000; bus.points = 4'h0; bus.les = 4'h0; bus.lz_en = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_an", 32'(bus.an), 32'h0000000F);
        chk("rst_le", 32'(bus.le), 32'h00000001);
        @(negedge clk);
        cycle();
        rst_n = 1'b1;

        // Idle after reset: blank for three cycles, digit 0 on the fourth.
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("pre_tick_an", 32'(bus.an), 32'h0000000F);
        end
        cycle();
        chk("tick1_an", 32'(bus.an), 32'h0000000E);
        chk("tick1_le", 32'(bus.le), 32'h00000000);
        chk("tick1_fs", 32'(bus.frame_start), 32'h00000001);
        for (int i = 0; i < 16; i++) cycle();
        chk("frame2_fs", 32'(bus.frame_start), 32'h00000001);
        chk("frame2_an", 32'(bus.an), 32'h0000000E);

        // Mid-frame load shows from the next digit 0.
        wait_an(4'b1011);
        load_frame(16'h12A5, 4'b0100, 4'b0000, 1'b0);
        wait_an(4'b0111); chk("old_d3", 32'(bus.hex), 32'h0);
        wait_an(4'b1110); chk("new_d0", 32'(bus.hex), 32'h5);
        wait_an(4'b1101); chk("new_d1", 32'(bus.hex), 32'hA);
        wait_an(4'b1011); chk("new_d2", 32'(bus.hex), 32'h2); chk("pt_d2", 32'(bus.point), 32'h1);
        wait_an(4'b0111); chk("new_d3", 32'(bus.hex), 32'h1); chk("pt_d3", 32'(bus.point), 32'h0);

        // Leading-zero blanking.
        load_frame(16'h0070, 4'b0000, 4'b0000, 1'b1);
        wait_an(4'b1110); chk("lz_d0_le", 32'(bus.le), 32'h0); chk("lz_d0_hex", 32'(bus.hex), 32'h0);
        wait_an(4'b1101); chk("lz_d1_le", 32'(bus.le), 32'h0); chk("lz_d1_hex", 32'(bus.hex), 32'h7);
        wait_an(4'b1011); chk("lz_d2_le", 32'(bus.le), 32'h1);
        wait_an(4'b0111); chk("lz_d3_le", 32'(bus.le), 32'h1);
        load_frame(16'h0000, 4'b0000, 4'b0000, 1'b1);
        wait_an(4'b1110); chk("z_d0_le", 32'(bus.le), 32'h0); chk("z_d0_hex", 32'(bus.hex), 32'h0);
        wait_an(4'b1101); chk("z_d1_le", 32'(bus.le), 32'h1);
        wait_an(4'b0111); chk("z_d3_le", 32'(bus.le), 32'h1);

        // Last write wins within a frame.
        wait_an(4'b1101);
        load_frame(16'h1111, 4'b0000, 4'b0000, 1'b0);
        wait_an(4'b1011);
        load_frame(16'h2222, 4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < 40; i++) begin
            cycle();
            chk("no1111", 32'(bus.hex == 4'h1), 32'h0);
        end
        wait_an(4'b1101); chk("lw_d1", 32'(bus.hex), 32'h2);

        // Load exactly on the commit tick bypasses into active.
        wait_an(4'b0111);
        for (int i = 0; i < SD - 1; i++) cycle();
        load_frame(16'h3339, 4'b0000, 4'b0000, 1'b0);
        chk("byp_an", 32'(bus.an), 32'hE);
        chk("byp_hex", 32'(bus.hex), 32'h9);
        wait_an(4'b1110); chk("byp_next", 32'(bus.hex), 32'h9);

        // Reset mid-scan discards pending data.
        wait_an(4'b1101);
        load_frame(16'hFFFF, 4'hF, 4'h0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mrst_an", 32'(bus.an), 32'hF);
        chk("mrst_le", 32'(bus.le), 32'h1);
        check_all();
        @(negedge clk);
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            chk("post_rst_zero", 32'(bus.hex), 32'h0);
        end

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            bus.load   = ($urandom_range(0, 7) == 0);
            bus.hexs   = 16'($urandom) >> (4 * $urandom_range(0, 4));
            bus.points = 4'($urandom);
            bus.les    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            bus.lz_en  = 1'($urandom);
            cycle();
        end
        bus.load = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
